// File: rtl/fifo2_ram_ctrl_pkg.sv
// Shared sizing constants and the per-cycle grant encoding for the
// FIFO-over-single-port-RAM controller.
package fifo2_pkg;

   localparam int DW    = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      GNT_NONE  = 2'd0,
      GNT_PUSH  = 2'd1,
      GNT_POP   = 2'd2,
      GNT_FLUSH = 2'd3
   } grant_t;

endpackage

// File: rtl/fifo2_ram_ctrl_if.sv
// Producer/consumer handshake plus RAM port bundle for fifo2_ram_ctrl.
// Handshake: a request is held with its data until the matching ack is high in
// the same cycle; the transfer happens at the rising edge that ends that cycle.
interface fifo2_ram_ctrl_if;
   import fifo2_pkg::*;

   logic          flush;
   logic          push_req;
   logic [DW-1:0] push_data;
   logic          push_ack;
   logic          pop_req;
   logic          pop_ack;
   logic [DW-1:0] pop_data;
   logic          pop_valid;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          ram_rws;
   logic          ram_cs;
   logic          ram_clear;
   grant_t        grant_dbg;

   modport slave (
      input  flush, push_req, push_data, pop_req, ram_dout,
      output push_ack, pop_ack, pop_data, pop_valid, full, empty, count,
             ram_addr, ram_din, ram_rws, ram_cs, ram_clear, grant_dbg
   );

   modport master (
      output flush, push_req, push_data, pop_req, ram_dout,
      input  push_ack, pop_ack, pop_data, pop_valid, full, empty, count,
             ram_addr, ram_din, ram_rws, ram_cs, ram_clear, grant_dbg
   );

endinterface

// File: rtl/fifo2_ram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]=push, req[1]=pop.
// last=1 means push won the previous grant, so pop wins the next tie.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/fifo2_ram_ctrl.sv
// Sequences push/pop traffic onto one single-port RAM so it behaves as a FIFO.
// One RAM access per cycle; flush outranks both requests.
module fifo2_ram_ctrl
   import fifo2_pkg::*;
(
   input  logic             clk,
   input  logic             clear_n,
   fifo2_ram_ctrl_if.slave  bus
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic [DW-1:0] pop_data_q, pop_data_d;
   logic          pop_valid_q, pop_valid_d;
   logic          last_push_q, last_push_d;
   logic [1:0]    req;
   logic [1:0]    gnt;
   grant_t        grant;

   assign req = {bus.pop_req & ~empty_q, bus.push_req & ~full_q};

   rr_arb2 u_arb (
      .req  (req),
      .last (last_push_q),
      .gnt  (gnt)
   );

   always_comb begin
      grant = GNT_NONE;
      if (clear_n) begin
         if (bus.flush)   grant = GNT_FLUSH;
         else if (gnt[0]) grant = GNT_PUSH;
         else if (gnt[1]) grant = GNT_POP;
      end
   end

   // Reset and flush both wipe the RAM; otherwise the port idles on rd_ptr.
   assign bus.push_ack  = (grant == GNT_PUSH);
   assign bus.pop_ack   = (grant == GNT_POP);
   assign bus.ram_cs    = (grant == GNT_PUSH) || (grant == GNT_POP);
   assign bus.ram_rws   = (grant == GNT_PUSH);
   assign bus.ram_addr  = (grant == GNT_PUSH) ? wr_ptr_q : rd_ptr_q;
   assign bus.ram_din   = (grant == GNT_PUSH) ? bus.push_data : '0;
   assign bus.ram_clear = !clear_n || (grant == GNT_FLUSH);
   assign bus.grant_dbg = grant;

   assign bus.pop_data  = pop_data_q;
   assign bus.pop_valid = pop_valid_q;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = count_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      full_d      = full_q;
      empty_d     = empty_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      last_push_d = last_push_q;
      case (grant)
         GNT_FLUSH: begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
            empty_d  = 1'b1;
         end
         GNT_PUSH: begin
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            count_d     = count_q + CNT_ONE;
            full_d      = (count_q == CNT_FULL - CNT_ONE);
            empty_d     = 1'b0;
            last_push_d = 1'b1;
         end
         GNT_POP: begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            count_d     = count_q - CNT_ONE;
            full_d      = 1'b0;
            empty_d     = (count_q == CNT_ONE);
            pop_data_d  = bus.ram_dout;
            pop_valid_d = 1'b1;
            last_push_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         last_push_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         last_push_q <= last_push_d;
      end
   end

endmodule

// File: tb/tb_fifo2_ram_ctrl.sv
// Self-checking bench for fifo2_ram_ctrl with a behavioural 4x4 RAM beside it.
// Accepted push data goes into exp_q; each pop_valid pulse is checked against its head.
module tb_fifo2_ram_ctrl;
   import fifo2_pkg::*;

   logic clk = 1'b0;
   logic clear_n;
   fifo2_ram_ctrl_if bus ();

   always #5 clk = ~clk;

   fifo2_ram_ctrl dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus.slave)
   );

   logic [3:0] mem [4];
   always @(posedge clk) begin
      if (bus.ram_clear) begin
         for (int i = 0; i < 4; i++) mem[i] <= 4'h0;
      end else if (bus.ram_cs && bus.ram_rws) begin
         mem[bus.ram_addr] <= bus.ram_din;
      end
   end
   assign bus.ram_dout = mem[bus.ram_addr];

   always @(negedge clk) begin
      if (clear_n) assert (bus.count <= 3'd4) else $error("count out of range: %0d", bus.count);
   end

   int n_cmp  = 0;
   int n_fail = 0;
   logic [3:0] exp_q [$];
   logic [3:0] exp_v;
   logic       s_push_ack, s_pop_ack, s_cs, s_rws, s_clear;
   logic [1:0] s_addr;
   logic [3:0] s_din;
   int         m_cnt;
   logic       m_last;

   task automatic cycle(input logic p, input logic [3:0] d, input logic q, input logic f);
      bus.push_req  = p;
      bus.push_data = d;
      bus.pop_req   = q;
      bus.flush     = f;
      @(negedge clk);
      s_push_ack = bus.push_ack;
      s_pop_ack  = bus.pop_ack;
      s_cs       = bus.ram_cs;
      s_rws      = bus.ram_rws;
      s_addr     = bus.ram_addr;
      s_din      = bus.ram_din;
      s_clear    = bus.ram_clear;
      if (bus.push_ack) exp_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_n = 1'b0;
      cycle(1'b1, 4'hF, 1'b1, 1'b0);
      n_cmp++; if (s_push_ack !== 1'b0) begin n_fail++; $display("FAIL rst_push_ack: got %b want 0", s_push_ack); end
      n_cmp++; if (s_pop_ack !== 1'b0) begin n_fail++; $display("FAIL rst_pop_ack: got %b want 0", s_pop_ack); end
      n_cmp++; if (s_cs !== 1'b0) begin n_fail++; $display("FAIL rst_ram_cs: got %b want 0", s_cs); end
      n_cmp++; if (s_clear !== 1'b1) begin n_fail++; $display("FAIL rst_ram_clear: got %b want 1", s_clear); end
      n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
      n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", bus.full); end
      n_cmp++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.count); end
      n_cmp++; if (bus.pop_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pop_valid: got %b want 0", bus.pop_valid); end
      n_cmp++; if (bus.pop_data !== 4'h0) begin n_fail++; $display("FAIL rst_pop_data: got %h want 0", bus.pop_data); end
      exp_q.delete();
      clear_n = 1'b1;
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
      n_cmp++; if (s_cs !== 1'b0) begin n_fail++; $display("FAIL idle_ram_cs: got %b want 0", s_cs); end
      n_cmp++; if (s_clear !== 1'b0) begin n_fail++; $display("FAIL idle_ram_clear: got %b want 0", s_clear); end
      n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty: got %b want 1", bus.empty); end
   endtask

   task automatic test_fill();
      logic [3:0] vals [4];
      vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'h3; vals[3] = 4'hC;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, vals[i], 1'b0, 1'b0);
         n_cmp++; if (s_push_ack !== 1'b1) begin n_fail++; $display("FAIL fill_ack[%0d]: got %b want 1", i, s_push_ack); end
         n_cmp++; if (s_addr !== 2'(i)) begin n_fail++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, s_addr, i); end
         n_cmp++; if (s_rws !== 1'b1 || s_cs !== 1'b1) begin n_fail++; $display("FAIL fill_rws_cs[%0d]: got %b%b want 11", i, s_rws, s_cs); end
         n_cmp++; if (s_din !== vals[i]) begin n_fail++; $display("FAIL fill_din[%0d]: got %h want %h", i, s_din, vals[i]); end
         n_cmp++; if (bus.full !== (i == 3)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i == 3)); end
      end
      n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", bus.count); end
      cycle(1'b1, 4'hF, 1'b0, 1'b0);
      n_cmp++; if (s_push_ack !== 1'b0 || s_cs !== 1'b0) begin n_fail++; $display("FAIL full_push_held: ack %b cs %b want 0 0", s_push_ack, s_cs); end
      n_cmp++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", bus.count); end
      bus.push_req = 1'b0;
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 4'h0, 1'b1, 1'b0);
         n_cmp++; if (s_pop_ack !== 1'b1 || s_rws !== 1'b0) begin n_fail++; $display("FAIL drain_ack[%0d]: ack %b rws %b want 1 0", i, s_pop_ack, s_rws); end
         n_cmp++; if (s_addr !== 2'(i)) begin n_fail++; $display("FAIL drain_addr[%0d]: got %0d want %0d", i, s_addr, i); end
         n_cmp++; if (bus.pop_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.pop_valid); end
         if (exp_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL drain_sb[%0d]: got pop with no expected entry", i); end
         else begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (bus.pop_data !== exp_v) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.pop_data, exp_v); end
         end
      end
      n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin n_fail++; $display("FAIL drain_empty: empty %b count %0d want 1 0", bus.empty, bus.count); end
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
      n_cmp++; if (bus.pop_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_pulse: got %b want 0", bus.pop_valid); end
   endtask

   task automatic test_empty_pop();
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      n_cmp++; if (s_pop_ack !== 1'b0 || s_cs !== 1'b0) begin n_fail++; $display("FAIL empty_pop: ack %b cs %b want 0 0", s_pop_ack, s_cs); end
      n_cmp++; if (bus.pop_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b want 0", bus.pop_valid); end
      cycle(1'b1, 4'h6, 1'b1, 1'b0);
      n_cmp++; if (s_push_ack !== 1'b1 || s_pop_ack !== 1'b0) begin n_fail++; $display("FAIL empty_push: push %b pop %b want 1 0", s_push_ack, s_pop_ack); end
      n_cmp++; if (s_addr !== 2'd0) begin n_fail++; $display("FAIL wr_wrap_addr: got %0d want 0", s_addr); end
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      n_cmp++; if (s_pop_ack !== 1'b1 || s_addr !== 2'd0) begin n_fail++; $display("FAIL rd_wrap: ack %b addr %0d want 1 0", s_pop_ack, s_addr); end
      if (exp_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL empty_sb: got pop with no expected entry"); end
      else begin
         exp_v = exp_q.pop_front();
         n_cmp++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp_v) begin n_fail++; $display("FAIL empty_then_data: valid %b data %h want 1 %h", bus.pop_valid, bus.pop_data, exp_v); end
      end
      bus.pop_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] d;
      for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      if (exp_q.size() != 0) exp_v = exp_q.pop_front();
      n_cmp++; if (bus.pop_data !== exp_v || bus.count !== 3'd2) begin n_fail++; $display("FAIL b2b_setup: data %h count %0d want %h 2", bus.pop_data, bus.count, exp_v); end
      for (int k = 0; k < 4; k++) begin
         d = 4'($urandom_range(0, 15));
         cycle(1'b1, d, 1'b1, 1'b0);
         n_cmp++; if (s_push_ack !== (k % 2 == 0) || s_pop_ack !== (k % 2 == 1)) begin
            n_fail++; $display("FAIL b2b_grant[%0d]: push %b pop %b want %b %b", k, s_push_ack, s_pop_ack, (k % 2 == 0), (k % 2 == 1));
         end
         if (k % 2 == 1) begin
            if (exp_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL b2b_sb[%0d]: got pop with no expected entry", k); end
            else begin
               exp_v = exp_q.pop_front();
               n_cmp++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp_v) begin n_fail++; $display("FAIL b2b_data[%0d]: valid %b data %h want 1 %h", k, bus.pop_valid, bus.pop_data, exp_v); end
            end
         end
      end
      n_cmp++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", bus.count); end
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
   endtask

   task automatic test_flush();
      cycle(1'b1, 4'h7, 1'b0, 1'b0);
      n_cmp++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_setup_count: got %0d want 3", bus.count); end
      cycle(1'b1, 4'h9, 1'b0, 1'b1);
      exp_q.delete();
      n_cmp++; if (s_push_ack !== 1'b0 || s_pop_ack !== 1'b0) begin n_fail++; $display("FAIL flush_acks: push %b pop %b want 0 0", s_push_ack, s_pop_ack); end
      n_cmp++; if (s_clear !== 1'b1 || s_cs !== 1'b0) begin n_fail++; $display("FAIL flush_ram: clear %b cs %b want 1 0", s_clear, s_cs); end
      n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         n_fail++; $display("FAIL flush_state: count %0d empty %b full %b want 0 1 0", bus.count, bus.empty, bus.full);
      end
      cycle(1'b1, 4'h9, 1'b0, 1'b0);
      n_cmp++; if (s_push_ack !== 1'b1 || s_addr !== 2'd0) begin n_fail++; $display("FAIL flush_repush: ack %b addr %0d want 1 0", s_push_ack, s_addr); end
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      if (exp_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL flush_sb: got pop with no expected entry"); end
      else begin
         exp_v = exp_q.pop_front();
         n_cmp++; if (s_addr !== 2'd0 || bus.pop_data !== exp_v) begin n_fail++; $display("FAIL flush_pop: addr %0d data %h want 0 %h", s_addr, bus.pop_data, exp_v); end
      end
      bus.pop_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 4'h2, 1'b0, 1'b0);
      cycle(1'b1, 4'h4, 1'b0, 1'b0);
      clear_n = 1'b0;
      cycle(1'b1, 4'h8, 1'b0, 1'b0);
      exp_q.delete();
      n_cmp++; if (s_push_ack !== 1'b0 || s_clear !== 1'b1) begin n_fail++; $display("FAIL midrst_comb: ack %b clear %b want 0 1", s_push_ack, s_clear); end
      n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.pop_data !== 4'h0) begin
         n_fail++; $display("FAIL midrst_state: count %0d empty %b data %h want 0 1 0", bus.count, bus.empty, bus.pop_data);
      end
      clear_n = 1'b1;
      bus.push_req = 1'b0;
   endtask

   task automatic test_random();
      logic p, q, el_p, el_q, g_push, g_pop;
      logic [3:0] d;
      m_cnt  = 0;
      m_last = 1'b0;
      for (int c = 0; c < 48; c++) begin
         p = 1'($urandom_range(0, 1));
         q = 1'($urandom_range(0, 1));
         d = 4'($urandom_range(0, 15));
         el_p   = p && (m_cnt < 4);
         el_q   = q && (m_cnt > 0);
         g_push = el_p && (!el_q || !m_last);
         g_pop  = el_q && !g_push;
         cycle(p, d, q, 1'b0);
         if (g_push) begin m_cnt++; m_last = 1'b1; end
         if (g_pop)  begin m_cnt--; m_last = 1'b0; end
         n_cmp++; if (s_push_ack !== g_push || s_pop_ack !== g_pop) begin
            n_fail++; $display("FAIL rnd_grant[%0d]: push %b pop %b want %b %b", c, s_push_ack, s_pop_ack, g_push, g_pop);
         end
         n_cmp++; if (bus.count !== 3'(m_cnt) || bus.full !== (m_cnt == 4) || bus.empty !== (m_cnt == 0)) begin
            n_fail++; $display("FAIL rnd_state[%0d]: count %0d full %b empty %b want %0d", c, bus.count, bus.full, bus.empty, m_cnt);
         end
         n_cmp++; if (bus.pop_valid !== g_pop) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.pop_valid, g_pop); end
         if (g_pop) begin
            if (exp_q.size() == 0) begin n_cmp++; n_fail++; $display("FAIL rnd_sb[%0d]: got pop with no expected entry", c); end
            else begin
               exp_v = exp_q.pop_front();
               n_cmp++; if (bus.pop_data !== exp_v) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, bus.pop_data, exp_v); end
            end
         end
      end
   endtask

   initial begin
      clear_n       = 1'b0;
      bus.flush     = 1'b0;
      bus.push_req  = 1'b0;
      bus.push_data = 4'h0;
      bus.pop_req   = 1'b0;
      exp_v         = 4'h0;
      test_reset();
      test_fill();
      test_drain();
      test_empty_pop();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo2_ram_ctrl.md
Name: fifo2_ram_ctrl

Overview:
Sequencing controller that turns the 4-word x 4-bit single-port RAM into a synchronous FIFO.
- Owns the write/read pointers and the occupancy count.
- Drives the RAM address, data, read/write select, chip select and clear.
- Arbitrates push and pop requests onto the one RAM port, since only one access is possible per cycle.
- Sits between the producer/consumer logic and the RAM instance.

Parameters:
DW, 4, data width; matches the RAM word width.
AW, 2, RAM address width.
DEPTH, 4, number of entries; always 1<<AW.

Ports:
clk  input  1  system clock, rising edge.
clear_n  input  1  synchronous active-low reset.
flush  input  1  synchronous FIFO flush request.
push_req  input  1  producer request; held with push_data until push_ack.
push_data  input  DW  write data.
push_ack  output  1  push granted this cycle (combinational).
pop_req  input  1  consumer request; held until pop_ack.
pop_ack  output  1  pop granted this cycle (combinational).
pop_data  output  DW  registered read data.
pop_valid  output  1  pop_data valid; one-cycle pulse.
full  output  1  count==DEPTH (registered).
empty  output  1  count==0 (registered).
count  output  AW+1  occupancy, 0..DEPTH.
ram_addr  output  AW  RAM address.
ram_din  output  DW  RAM write data.
ram_dout  input  DW  RAM read data (combinational read path).
ram_rws  output  1  1=write, 0=read.
ram_cs  output  1  RAM chip select.
ram_clear  output  1  RAM clear.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clear_n sampled on rising clk).
- Registers while clear_n=0: wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1, pop_data=0, pop_valid=0, last_push=0.
- Combinational outputs while clear_n=0: push_ack=0, pop_ack=0, ram_cs=0, ram_rws=0, ram_clear=1.
- Eligibility, computed each cycle: push_el=push_req & !full; pop_el=pop_req & !empty.
- Grant priority: flush > arbitration.
  - Flush cycle: no acks, ram_cs=0, ram_clear=1. Next edge: pointers=0, count=0, empty=1, full=0, pop_valid=0.
- Arbitration, handled by the 2-way round-robin:
  - Only one of push_el/pop_el set: that one wins.
  - Both set: the one not granted last time wins. last_push resets to 0, so push wins the first tie.
  - last_push updates only on a push or pop grant.
- GNT_PUSH cycle:
  - Drives: push_ack=1, ram_cs=1, ram_rws=1, ram_addr=wr_ptr, ram_din=push_data.
  - Next edge: wr_ptr+1 (mod DEPTH), count+1.
- GNT_POP cycle:
  - Drives: pop_ack=1, ram_cs=1, ram_rws=0, ram_addr=rd_ptr.
  - Next edge: pop_data<=ram_dout, pop_valid<=1, rd_ptr+1 (mod DEPTH), count-1.
  - Read latency: data valid the cycle after pop_ack.
- GNT_NONE cycle: ram_cs=0, ram_rws=0, ram_addr=rd_ptr, ram_din=0, ram_clear=0. pop_valid<=0, pop_data holds.
- Pointer wrap: AW-bit natural wrap, 3->0. Full/empty are derived from count, never from pointer compare.
- full/empty update at the same edge as count. A push while count==DEPTH-1 sets full at the next edge.
- Push while full, or pop while empty: no ack, no RAM access, state unchanged; the request stays pending.
- Push and pop together: exactly one served per cycle. Throughput is one access per cycle; with both requests continuously eligible, the port alternates push/pop.
- Reset asserted mid-operation: the in-flight access is abandoned and all state returns to reset values at that edge. RAM contents are cleared via ram_clear.
- count never exceeds DEPTH nor goes below 0; this is an assertion in the bench.

Decomposition:
- Package fifo2_pkg holds:
  - constants DW, AW, DEPTH;
  - enum grant_t {GNT_NONE, GNT_PUSH, GNT_POP, GNT_FLUSH}.
- Sub-module rr_arb2: 2-requester round-robin arbiter.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt.
  - Its priority-state register is kept in the parent.
- The RAM itself stays external and is instantiated beside the controller.

Test Plan:
- Reset, then idle -> empty=1, full=0, count=0, ram_cs=0, pop_valid=0, ram_clear=1 while clear_n=0.
- Push 0xA, 0x5, 0x3, 0xC on consecutive cycles -> push_ack each cycle; ram_addr 0,1,2,3 with ram_rws=1; count 4, full=1. A fifth push (0xF) is held with no ack.
- From full, pop four times -> pop_data 0xA, 0x5, 0x3, 0xC with pop_valid one cycle after each pop_ack; empty=1; wr_ptr and rd_ptr have wrapped to 0.
- count=2, push_req and pop_req held high together for 4 cycles -> grants alternate push, pop, push, pop (push first after reset); count ends at 2; no cycle has two acks.
- Pop with empty=1 -> pop_ack=0, ram_cs=0, pop_valid stays 0. Then push 0x6 -> the next cycle pops and returns 0x6.
- count=3, assert flush with push_req=1 -> no push_ack, ram_clear=1, ram_cs=0. Next cycle count=0, empty=1, and the pending push is accepted at ram_addr 0.
